plru_ctrl: RTL and testbench

PLRU_CTRL -- requirements
Module: plru_ctrl

---
 rtl/plru_ctrl.sv | 147 ++++++++++++++
 tb/tb_plru_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/plru_ctrl.sv
// Tree pseudo-LRU controller for a 4-way set-associative cache.
// Two-stage pipeline: S0 reads the set's tree state, and S1 answers and writes the updated state back.
module plru_ctrl #(
  parameter int S_INDEX = 4,
  parameter int WAYS    = 4
) (
  input  logic                    clk0,
  input  logic                    rst0,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [S_INDEX-1:0]      req_set,
  input  logic                    req_hit,
  input  logic [$clog2(WAYS)-1:0] req_way,
  input  logic                    req_touch,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [$clog2(WAYS)-1:0] resp_way,
  output logic                    lru_csb0,
  output logic                    lru_web0,
  output logic [S_INDEX-1:0]      lru_addr0,
  input  logic [2:0]              lru_dout0,
  output logic                    lru_csb1,
  output logic                    lru_web1,
  output logic [S_INDEX-1:0]      lru_addr1,
  output logic [2:0]              lru_din1,
  output logic [15:0]             miss_count
);

  localparam int WAY_W = $clog2(WAYS);

  // Tree bits are {b2, b1, b0}: b0 picks the pair, b1/b2 pick within the pair.
  function automatic logic [WAY_W-1:0] victim_of(input logic [2:0] st);
    logic [WAY_W-1:0] v;
    if (st[0] == 1'b0) begin
      v = st[1] ? 2'd1 : 2'd0;
    end else begin
      v = st[2] ? 2'd3 : 2'd2;
    end
    return v;
  endfunction

  function automatic logic [2:0] point_away(input logic [2:0] st, input logic [WAY_W-1:0] way);
    logic [2:0] n;
    case (way)
      2'd0:    n = {st[2], 1'b1, 1'b1};
      2'd1:    n = {st[2], 1'b0, 1'b1};
      2'd2:    n = {1'b1, st[1], 1'b0};
      2'd3:    n = {1'b0, st[1], 1'b0};
      default: n = st;
    endcase
    return n;
  endfunction

  logic               s1_valid_q, s1_valid_d;
  logic [S_INDEX-1:0] s1_set_q,   s1_set_d;
  logic               s1_hit_q,   s1_hit_d;
  logic [WAY_W-1:0]   s1_way_q,   s1_way_d;
  logic               s1_touch_q, s1_touch_d;
  logic               s1_fresh_q, s1_fresh_d;
  logic [2:0]         hold_q,     hold_d;
  logic [15:0]        miss_q,     miss_d;

  logic       req_fire;
  logic       resp_fire;
  logic [2:0] cur_state;

  // Handshake, read port and response path.
  // The array's read data is only valid the cycle after the read, so it is captured into hold_q to keep resp_way stable across stalls.
  always_comb begin
    req_ready  = !rst0 && (!s1_valid_q || resp_ready);
    req_fire   = req_valid && req_ready;
    resp_valid = s1_valid_q && !rst0;
    resp_fire  = resp_valid && resp_ready;
    cur_state  = s1_fresh_q ? lru_dout0 : hold_q;
    resp_way   = s1_hit_q ? s1_way_q : victim_of(cur_state);
    lru_csb0   = !req_fire;
    lru_web0   = 1'b1;
    lru_addr0  = req_set;
    lru_addr1  = s1_set_q;
    lru_din1   = point_away(cur_state, resp_way);
    miss_count = miss_q;
  end

  // Write port: write only on a touched response; otherwise leave the port selected in read mode.
  always_comb begin
    if (rst0) begin
      lru_csb1 = 1'b1;
      lru_web1 = 1'b1;
    end else if (resp_fire && s1_touch_q) begin
      lru_csb1 = 1'b0;
      lru_web1 = 1'b0;
    end else begin
      lru_csb1 = 1'b0;
      lru_web1 = 1'b1;
    end
  end

  // Next-state logic for the S1 stage and the miss counter.
  always_comb begin
    s1_set_d   = s1_set_q;
    s1_hit_d   = s1_hit_q;
    s1_way_d   = s1_way_q;
    s1_touch_d = s1_touch_q;
    s1_fresh_d = req_fire;
    hold_d     = cur_state;
    if (req_fire) begin
      s1_valid_d = 1'b1;
      s1_set_d   = req_set;
      s1_hit_d   = req_hit;
      s1_way_d   = req_way;
      s1_touch_d = req_touch;
    end else if (resp_fire) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (req_fire && !req_hit) begin
      miss_d = miss_q + 16'd1;
    end else begin
      miss_d = miss_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      s1_valid_q <= 1'b0;
      s1_set_q   <= {S_INDEX{1'b0}};
      s1_hit_q   <= 1'b0;
      s1_way_q   <= {WAY_W{1'b0}};
      s1_touch_q <= 1'b0;
      s1_fresh_q <= 1'b0;
      hold_q     <= 3'b000;
      miss_q     <= 16'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_set_q   <= s1_set_d;
      s1_hit_q   <= s1_hit_d;
      s1_way_q   <= s1_way_d;
      s1_touch_q <= s1_touch_d;
      s1_fresh_q <= s1_fresh_d;
      hold_q     <= hold_d;
      miss_q     <= miss_d;
    end
  end

endmodule

// File: tb/tb_plru_ctrl.sv
// Self-checking bench for plru_ctrl: behavioural LRU array with same-set bypass,
// reference PLRU model feeding an in-order scoreboard of expected response ways.
module tb_plru_ctrl;

  logic       clk = 1'b0;
  logic       rst0;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_set;
  logic       req_hit;
  logic [1:0] req_way;
  logic       req_touch;
  logic       resp_valid;
  logic       resp_ready;
  logic [1:0] resp_way;
  logic       lru_csb0, lru_web0, lru_csb1, lru_web1;
  logic [3:0] lru_addr0, lru_addr1;
  logic [2:0] lru_dout0, lru_din1;
  logic [15:0] miss_count;

  logic rdy_man;
  logic rand_rdy;
  logic rnd_bit;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  logic [2:0] mem [16];
  logic [2:0] ref_state [16];
  logic [1:0] sb [$];
  logic [15:0] exp_miss;

  assign resp_ready = rand_rdy ? rnd_bit : rdy_man;

  always #5 clk = ~clk;

  plru_ctrl #(.S_INDEX(4), .WAYS(4)) dut (
    .clk0(clk), .rst0(rst0),
    .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set),
    .req_hit(req_hit), .req_way(req_way), .req_touch(req_touch),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_way(resp_way),
    .lru_csb0(lru_csb0), .lru_web0(lru_web0), .lru_addr0(lru_addr0), .lru_dout0(lru_dout0),
    .lru_csb1(lru_csb1), .lru_web1(lru_web1), .lru_addr1(lru_addr1), .lru_din1(lru_din1),
    .miss_count(miss_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_victim(input logic [2:0] st);
    if (!st[0]) return st[1] ? 2'd1 : 2'd0;
    else        return st[2] ? 2'd3 : 2'd2;
  endfunction

  function automatic logic [2:0] ref_next(input logic [2:0] st, input logic [1:0] w);
    case (w)
      2'd0:    return {st[2], 2'b11};
      2'd1:    return {st[2], 2'b01};
      2'd2:    return {1'b1, st[1], 1'b0};
      default: return {1'b0, st[1], 1'b0};
    endcase
  endfunction

  // LRU array model: synchronous read, write-to-read bypass on the same set.
  always @(posedge clk) begin
    if (!lru_csb0 && lru_web0)
      lru_dout0 <= (!lru_csb1 && !lru_web1 && lru_addr1 == lru_addr0) ? lru_din1 : mem[lru_addr0];
    if (!lru_csb1 && !lru_web1) begin
      mem[lru_addr1] <= lru_din1;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // Scoreboard: compare responses first, then record the newly accepted request.
  always @(negedge clk) begin
    logic [1:0] w;
    if (resp_valid && resp_ready) begin
      if (sb.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
      else chk("resp_way", {30'd0, resp_way}, {30'd0, sb.pop_front()});
    end
    if (req_valid && req_ready) begin
      w = req_hit ? req_way : ref_victim(ref_state[req_set]);
      sb.push_back(w);
      if (req_touch) ref_state[req_set] = ref_next(ref_state[req_set], w);
      if (!req_hit) exp_miss = exp_miss + 16'd1;
    end
  end

  task automatic send(input logic [3:0] s, input logic h, input logic [1:0] w, input logic t);
    int n;
    req_valid = 1'b1; req_set = s; req_hit = h; req_way = w; req_touch = t;
    n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 50) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] held_way;
    logic [2:0] saved;
    int wr0;
    for (int i = 0; i < 16; i++) begin mem[i] = 3'b000; ref_state[i] = 3'b000; end
    lru_dout0 = 3'b000;
    exp_miss = 16'd0;
    rst0 = 1'b1; req_valid = 1'b0; req_set = 4'd0; req_hit = 1'b0; req_way = 2'd0;
    req_touch = 1'b0; rdy_man = 1'b1; rand_rdy = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_csb0", {31'd0, lru_csb0}, 32'd1);
    chk("rst_csb1", {31'd0, lru_csb1}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1; rst0 = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_miss", {16'd0, miss_count}, 32'd0);
    @(posedge clk); #1;

    // First miss on set 5 returns way0 and writes 011
    send(4'd5, 1'b0, 2'd0, 1'b1);
    idle(3);
    chk("set5_first", {29'd0, mem[5]}, 32'd3);

    // Back-to-back misses on set 5 rely on the array bypass
    send(4'd5, 1'b0, 2'd0, 1'b1);
    send(4'd5, 1'b0, 2'd0, 1'b1);
    idle(3);
    chk("set5_final", {29'd0, mem[5]}, {29'd0, ref_state[5]});

    // Query-only hit on way3 of set 2
    req_valid = 1'b1; req_set = 4'd2; req_hit = 1'b1; req_way = 2'd3; req_touch = 1'b0;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    chk("hit_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("hit_no_write", {31'd0, lru_web1}, 32'd1);
    idle(2);
    chk("set2_unchanged", {29'd0, mem[2]}, 32'd0);

    // Stall with S1 full: nothing moves, one write on release
    rdy_man = 1'b0;
    send(4'd7, 1'b0, 2'd0, 1'b1);
    held_way = resp_way;
    wr0 = wr_cnt;
    req_valid = 1'b1; req_set = 4'd8; req_hit = 1'b1; req_way = 2'd1; req_touch = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
      chk("stall_resp_way", {30'd0, resp_way}, {30'd0, held_way});
      chk("stall_no_read", {31'd0, lru_csb0}, 32'd1);
      chk("stall_no_write", {31'd0, lru_web1}, 32'd1);
    end
    @(posedge clk); #1; rdy_man = 1'b1;
    @(negedge clk);
    chk("release_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1; req_valid = 1'b0;
    idle(3);
    chk("release_one_write", wr_cnt - wr0, 32'd1);
    chk("release_drained", sb.size(), 32'd0);

    // Reset while a response is pending
    rdy_man = 1'b0;
    saved = ref_state[9];
    send(4'd9, 1'b0, 2'd0, 1'b1);
    wr0 = wr_cnt;
    @(negedge clk);
    chk("pre_rst_resp_valid", {31'd0, resp_valid}, 32'd1);
    @(posedge clk); #1; rst0 = 1'b1;
    @(negedge clk);
    chk("midrst_csb1", {31'd0, lru_csb1}, 32'd1);
    @(posedge clk); #1; rst0 = 1'b0; rdy_man = 1'b1;
    @(negedge clk);
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_miss", {16'd0, miss_count}, 32'd0);
    chk("midrst_no_write", wr_cnt - wr0, 32'd0);
    sb.delete();
    ref_state[9] = saved;
    exp_miss = 16'd0;
    @(posedge clk); #1;

    // Random traffic with random back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++)
      send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)));
    rand_rdy = 1'b0;
    idle(4);
    chk("rand_drained", sb.size(), 32'd0);
    chk("rand_miss", {16'd0, miss_count}, {16'd0, exp_miss});
    for (int i = 0; i < 16; i++) chk("array_state", {29'd0, mem[i]}, {29'd0, ref_state[i]});

    // Miss counter wrap
    rst0 = 1'b1;
    idle(1);
    rst0 = 1'b0;
    sb.delete();
    exp_miss = 16'd0;
    req_valid = 1'b1; req_hit = 1'b0; req_way = 2'd0; req_touch = 1'b0;
    for (int i = 0; i < 65537; i++) begin
      req_set = 4'(i);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    idle(3);
    chk("miss_wrap", {16'd0, miss_count}, 32'd1);
    chk("miss_wrap_model", {16'd0, miss_count}, {16'd0, exp_miss});
    chk("wrap_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
